// File: rtl/reservation_station.sv
// reservation_station: age-ordered compacting queue of DEPTH instructions.
// Pending operands carry a rename tag in op[TAG_W-1:0] and wake when the CDB
// broadcasts that tag. The oldest fully-ready entry is issued with a
// valid/ready handshake; younger entries shift down one slot on issue.
// Optional feature macro: RS_ISSUE_BYPASS_EN. When defined, a ready incoming
// instruction is presented on issue_* in the same cycle if no stored entry is
// ready. If issue_ready is also high, that instruction is never stored.
module reservation_station #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2*DATA_W+11:0]       in_inst,
  input  logic                       cdb_valid,
  input  logic [TAG_W-1:0]           cdb_tag,
  input  logic [DATA_W-1:0]          cdb_data,
  output logic                       issue_valid,
  input  logic                       issue_ready,
  output logic [DATA_W-1:0]          issue_op1,
  output logic [DATA_W-1:0]          issue_op2,
  output logic [4:0]                 issue_rd,
  output logic [4:0]                 issue_ctrl,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic              busy;
    logic [DATA_W-1:0] op1;
    logic              v1;
    logic [DATA_W-1:0] op2;
    logic              v2;
    logic [4:0]        rd;
    logic [4:0]        ctrl;
  } entry_t;

  entry_t            ent_q [DEPTH];
  entry_t            ent_d [DEPTH];
  entry_t            woken [DEPTH];
  entry_t            inc;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic [CNT_W-1:0]  count_after;
  logic [IDX_W-1:0]  sel_idx;
  logic              stored_ready;
  logic              pop;
  logic              push;
  logic              byp_take;

  assign count    = count_q;
  assign in_ready = (count_q < CNT_W'(DEPTH));

  // Unpack the incoming word and capture a same-cycle CDB result for it.
  always_comb begin
    // NOTE: every variable gets a default before any conditional update, so
    // no path leaves a value unassigned and no latch is inferred.
    inc      = '0;
    inc.busy = 1'b1;
    inc.ctrl = in_inst[4:0];
    inc.rd   = in_inst[9:5];
    inc.v1   = in_inst[10];
    inc.op1  = in_inst[DATA_W+10:11];
    inc.v2   = in_inst[DATA_W+11];
    inc.op2  = in_inst[2*DATA_W+11:DATA_W+12];
    if (cdb_valid && !inc.v1 && (inc.op1[TAG_W-1:0] == cdb_tag)) begin
      inc.op1 = cdb_data;
      inc.v1  = 1'b1;
    end
    if (cdb_valid && !inc.v2 && (inc.op2[TAG_W-1:0] == cdb_tag)) begin
      inc.op2 = cdb_data;
      inc.v2  = 1'b1;
    end
  end

  // Pick the lowest-index (oldest) stored entry with both operands valid.
  always_comb begin
    stored_ready = 1'b0;
    sel_idx      = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent_q[i].busy && ent_q[i].v1 && ent_q[i].v2) begin
        stored_ready = 1'b1;
        sel_idx      = IDX_W'(i);
      end
    end
  end

  // Drive issue_* from the selected entry (or the bypassed input); zero when idle.
  always_comb begin
    issue_valid = 1'b0;
    issue_op1   = '0;
    issue_op2   = '0;
    issue_rd    = '0;
    issue_ctrl  = '0;
    if (stored_ready) begin
      issue_valid = 1'b1;
      issue_op1   = ent_q[sel_idx].op1;
      issue_op2   = ent_q[sel_idx].op2;
      issue_rd    = ent_q[sel_idx].rd;
      issue_ctrl  = ent_q[sel_idx].ctrl;
    end
`ifdef RS_ISSUE_BYPASS_EN
    else if (in_valid && in_ready && inc.v1 && inc.v2) begin
      issue_valid = 1'b1;
      issue_op1   = inc.op1;
      issue_op2   = inc.op2;
      issue_rd    = inc.rd;
      issue_ctrl  = inc.ctrl;
    end
`endif
  end

  // Next state: wakeup, remove-and-compact on issue, append insert, flush last.
  always_comb begin
    pop      = stored_ready && issue_ready;
    byp_take = 1'b0;
`ifdef RS_ISSUE_BYPASS_EN
    byp_take = !stored_ready && in_valid && in_ready && inc.v1 && inc.v2 && issue_ready;
`endif
    push        = in_valid && in_ready && !byp_take;
    count_after = count_q - {{(CNT_W-1){1'b0}}, pop};
    count_d     = count_after + {{(CNT_W-1){1'b0}}, push};

    for (int i = 0; i < DEPTH; i++) begin
      woken[i] = ent_q[i];
      if (cdb_valid && woken[i].busy) begin
        if (!woken[i].v1 && (woken[i].op1[TAG_W-1:0] == cdb_tag)) begin
          woken[i].op1 = cdb_data;
          woken[i].v1  = 1'b1;
        end
        if (!woken[i].v2 && (woken[i].op2[TAG_W-1:0] == cdb_tag)) begin
          woken[i].op2 = cdb_data;
          woken[i].v2  = 1'b1;
        end
      end
    end

    // Slots at or above the issued one take their younger neighbour.
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (pop && (IDX_W'(i) >= sel_idx)) ent_d[i] = woken[i+1];
      else                               ent_d[i] = woken[i];
    end
    ent_d[DEPTH-1] = pop ? '0 : woken[DEPTH-1];

    for (int i = 0; i < DEPTH; i++) begin
      if (push && (CNT_W'(i) == count_after)) ent_d[i] = inc;
    end

    if (flush) begin
      count_d = '0;
      for (int i = 0; i < DEPTH; i++) ent_d[i] = '0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      count_q <= '0;
      // NOTE: only the busy flags are reset; payload fields are don't-care
      // while busy=0 and issue_* is forced to zero when nothing is ready.
      for (int i = 0; i < DEPTH; i++) ent_q[i].busy <= 1'b0;
    end else begin
      count_q <= count_d;
      ent_q   <= ent_d;
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Self-checking bench for reservation_station: a queue-based reference model
// predicts each cycle's outputs; expected issue payloads go to a scoreboard
// that a separate monitor drains whenever the DUT asserts issue_valid.
module tb_reservation_station;

  localparam int DEPTH  = 4;
  localparam int TAG_W  = 5;
  localparam int DATA_W = 32;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int INST_W = 2 * DATA_W + 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [INST_W-1:0] in_inst;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              issue_valid;
  logic              issue_ready;
  logic [DATA_W-1:0] issue_op1;
  logic [DATA_W-1:0] issue_op2;
  logic [4:0]        issue_rd;
  logic [4:0]        issue_ctrl;
  logic [CNT_W-1:0]  count;

  reservation_station #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_op1(issue_op1), .issue_op2(issue_op2),
    .issue_rd(issue_rd), .issue_ctrl(issue_ctrl), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    logic        v1;
    logic        v2;
    logic [4:0]  rd;
    logic [4:0]  ctrl;
  } ent_t;

  ent_t mq[$];     // reference model: oldest instruction at index 0
  ent_t exp_q[$];  // scoreboard of expected issue payloads
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [INST_W-1:0] mk(input logic [31:0] op1, input logic v1,
                                           input logic [31:0] op2, input logic v2,
                                           input logic [4:0] rd, input logic [4:0] ctrl);
    return {op2, v2, op1, v1, rd, ctrl};
  endfunction

  task automatic drive(input logic iv, input logic [INST_W-1:0] inst, input logic cv,
                       input logic [4:0] ct, input logic [31:0] cd,
                       input logic ir, input logic fl);
    rst = 1'b0; in_valid = iv; in_inst = inst; cdb_valid = cv;
    cdb_tag = ct; cdb_data = cd; issue_ready = ir; flush = fl;
  endtask

  task automatic idle(input logic ir);
    drive(1'b0, '0, 1'b0, 5'd0, 32'd0, ir, 1'b0);
  endtask

  task automatic settle();
    #1;
  endtask

  // One clock: predict outputs from the model, compare, then advance the model.
  task automatic step();
    int   sel;
    ent_t inc;
    bit   exp_inr;
    bit   exp_v;
    bit   byp;
    #1;
    sel = -1;
    for (int i = 0; i < mq.size(); i++)
      if (sel < 0 && mq[i].v1 && mq[i].v2) sel = i;
    exp_inr  = (mq.size() < DEPTH);
    inc.ctrl = in_inst[4:0];
    inc.rd   = in_inst[9:5];
    inc.v1   = in_inst[10];
    inc.op1  = in_inst[42:11];
    inc.v2   = in_inst[43];
    inc.op2  = in_inst[75:44];
    if (cdb_valid && !inc.v1 && inc.op1[4:0] == cdb_tag) begin inc.op1 = cdb_data; inc.v1 = 1'b1; end
    if (cdb_valid && !inc.v2 && inc.op2[4:0] == cdb_tag) begin inc.op2 = cdb_data; inc.v2 = 1'b1; end
    byp   = 1'b0;
    exp_v = (sel >= 0);
`ifdef RS_ISSUE_BYPASS_EN
    if (!exp_v && in_valid && exp_inr && inc.v1 && inc.v2) begin byp = 1'b1; exp_v = 1'b1; end
`endif
    check("count", 64'(count), 64'(mq.size()));
    check("in_ready", 64'(in_ready), 64'(exp_inr));
    check("issue_valid", 64'(issue_valid), 64'(exp_v));
    if (byp) exp_q.push_back(inc);
    else if (exp_v) exp_q.push_back(mq[sel]);
    else begin
      check("idle_op1", 64'(issue_op1), 64'd0);
      check("idle_op2", 64'(issue_op2), 64'd0);
      check("idle_rd_ctrl", 64'({issue_rd, issue_ctrl}), 64'd0);
    end
    if (rst || flush) mq.delete();
    else begin
      foreach (mq[i]) begin
        if (cdb_valid && !mq[i].v1 && mq[i].op1[4:0] == cdb_tag) begin mq[i].op1 = cdb_data; mq[i].v1 = 1'b1; end
        if (cdb_valid && !mq[i].v2 && mq[i].op2[4:0] == cdb_tag) begin mq[i].op2 = cdb_data; mq[i].v2 = 1'b1; end
      end
      if (sel >= 0 && issue_ready) mq.delete(sel);
      if (in_valid && exp_inr && !(byp && issue_ready)) mq.push_back(inc);
    end
    @(negedge clk);
  endtask

  // Monitor: every cycle the DUT presents an instruction, compare with the scoreboard.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      #4;
      if (mon_en && issue_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL issue_unexpected: got issue_valid=1 rd=%0d, expected nothing queued (t=%0t)", issue_rd, $time);
        end else begin
          e = exp_q.pop_front();
          check("issue_op1", 64'(issue_op1), 64'(e.op1));
          check("issue_op2", 64'(issue_op2), 64'(e.op2));
          check("issue_rd", 64'(issue_rd), 64'(e.rd));
          check("issue_ctrl", 64'(issue_ctrl), 64'(e.ctrl));
        end
      end
    end
  end

  function automatic logic [31:0] rand_op(input logic v);
    logic [31:0] r;
    r = $urandom;
    if (!v) r[4:0] = 5'($urandom_range(0, 7));
    return r;
  endfunction

  initial begin
    logic v1, v2;
    idle(1'b0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;

    // Minimum-latency issue of an already-ready instruction.
    drive(1'b1, mk(32'd5, 1'b1, 32'd7, 1'b1, 5'd3, 5'd1), 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    step();
    idle(1'b1);
    settle();
`ifdef RS_ISSUE_BYPASS_EN
    check("t2_count_bypassed", 64'(count), 64'd0);
`else
    check("t2_issue_valid", 64'(issue_valid), 64'd1);
    check("t2_op1", 64'(issue_op1), 64'd5);
    check("t2_op2", 64'(issue_op2), 64'd7);
    check("t2_rd", 64'(issue_rd), 64'd3);
    check("t2_count_one", 64'(count), 64'd1);
`endif
    step();
    settle();
    check("t2_count_zero", 64'(count), 64'd0);

    // Younger ready B overtakes pending A; A then issues with the CDB value.
    drive(1'b1, mk(32'h9, 1'b0, 32'h22, 1'b1, 5'd1, 5'd2), 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    step();
    drive(1'b1, mk(32'h33, 1'b1, 32'h44, 1'b1, 5'd2, 5'd3), 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    step();
    drive(1'b0, '0, 1'b1, 5'd9, 32'hDEAD, 1'b1, 1'b0);
`ifndef RS_ISSUE_BYPASS_EN
    settle();
    check("t3_b_first", 64'(issue_rd), 64'd2);
`endif
    step();
    idle(1'b1);
    settle();
    check("t3_a_op1", 64'(issue_op1), 64'hDEAD);
    check("t3_a_rd", 64'(issue_rd), 64'd1);
    step();

    // Fill with pending entries, refuse an insert when full, then wake out of order.
    for (int k = 0; k < DEPTH; k++) begin
      drive(1'b1, mk(32'(10 + k), 1'b0, 32'(k), 1'b1, 5'(4 + k), 5'(k)), 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
      step();
    end
    drive(1'b1, mk(32'd1, 1'b1, 32'd2, 1'b1, 5'd9, 5'd9), 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    settle();
    check("t4_full_in_ready", 64'(in_ready), 64'd0);
    check("t4_full_count", 64'(count), 64'd4);
    step();
    drive(1'b0, '0, 1'b1, 5'd12, 32'h1200, 1'b0, 1'b0);
    step();
    idle(1'b1);
    step();
    idle(1'b0);
    settle();
    check("t4_in_ready_after_issue", 64'(in_ready), 64'd1);
    check("t4_count_after_issue", 64'(count), 64'd3);
    drive(1'b0, '0, 1'b1, 5'd13, 32'h1300, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, 1'b1, 5'd11, 32'h1100, 1'b0, 1'b0);
    step();
    idle(1'b1);
    repeat (2) step();
    drive(1'b0, '0, 1'b1, 5'd10, 32'h1000, 1'b1, 1'b0);
    step();
    idle(1'b1);
    repeat (2) step();

    // Insert-time capture from the CDB; upper tag bits are ignored.
    drive(1'b1, mk(32'hABCD_E004, 1'b0, 32'h55, 1'b1, 5'd8, 5'd4), 1'b1, 5'd4, 32'h11, 1'b1, 1'b0);
    step();
    idle(1'b1);
`ifndef RS_ISSUE_BYPASS_EN
    settle();
    check("t5_capture_valid", 64'(issue_valid), 64'd1);
    check("t5_capture_op1", 64'(issue_op1), 64'h11);
`endif
    step();

    // Stall for three cycles, then flush while inserting.
    drive(1'b1, mk(32'd1, 1'b1, 32'd2, 1'b1, 5'd10, 5'd5), 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    step();
    idle(1'b0);
    repeat (3) step();
    drive(1'b1, mk(32'd3, 1'b1, 32'd4, 1'b1, 5'd11, 5'd6), 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    step();
    idle(1'b0);
    settle();
    check("t6_flush_count", 64'(count), 64'd0);
    check("t6_flush_valid", 64'(issue_valid), 64'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      v1 = ($urandom_range(0, 9) < 6);
      v2 = ($urandom_range(0, 9) < 6);
      drive(1'($urandom_range(0, 1)),
            mk(rand_op(v1), v1, rand_op(v2), v2, 5'($urandom), 5'($urandom)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 9) < 7), ($urandom_range(0, 49) == 0));
      step();
    end

    // Synchronous reset in the middle of traffic, held for two cycles.
    for (int c = 0; c < 2; c++) begin
      v1 = 1'b1;
      drive(1'b1, mk(rand_op(v1), v1, rand_op(v1), v1, 5'($urandom), 5'($urandom)),
            1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
      rst = 1'b1;
      step();
    end
    idle(1'b1);
    settle();
    check("t1_rst_count", 64'(count), 64'd0);
    check("t1_rst_valid", 64'(issue_valid), 64'd0);
    check("t1_rst_in_ready", 64'(in_ready), 64'd1);
    check("t1_rst_op1", 64'(issue_op1), 64'd0);

    // More traffic, then drain by broadcasting every tag.
    for (int c = 0; c < 200; c++) begin
      v1 = ($urandom_range(0, 9) < 5);
      v2 = ($urandom_range(0, 9) < 5);
      drive(1'($urandom_range(0, 1)),
            mk(rand_op(v1), v1, rand_op(v2), v2, 5'($urandom), 5'($urandom)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 1)), 1'b0);
      step();
    end
    for (int c = 0; c < 96; c++) begin
      drive(1'b0, '0, 1'b1, 5'(c % 32), $urandom, 1'b1, 1'b0);
      step();
    end
    idle(1'b1);
    repeat (4) step();
    #5;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
